// File: rtl/sram_pkg.sv
// Shared SRAM geometry, read latency and read-return bookkeeping types
// for the SRAM port arbiter.
package sram_pkg;

  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_RD_LAT     = 2;

  // Wide enough for the largest supported channel count (8).
  typedef logic [2:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t ch;
  } rd_slot_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: request, direction,
// address, write data and the returned one-hot grant.
interface sram_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;

  modport master (output req, we, addr, wdata, input gnt);
  modport slave  (input req, we, addr, wdata, output gnt);

endinterface

// File: rtl/sram_arb_picker.sv
// Combinational one-hot grant: first requesting channel found when scanning
// upward from ptr (ptr tied to 0 gives fixed lowest-index priority).
module sram_arb_picker
  import sram_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  sram_port_arbiter_if.slave bus,
  input  ch_id_t             ptr
);

  logic found;
  int   idx;

  // NOTE: every always_comb output gets a default before any branch, so a
  // path that never assigns it cannot infer a latch.
  always_comb begin
    bus.gnt = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && bus.req[idx]) begin
        bus.gnt[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-channel arbiter onto one pipelined single-port SRAM. Default build is
// fixed priority (channel 0 highest); define SRAM_ARB_RR_EN for round-robin.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = SRAM_ADDR_COUNT,
  parameter int DATA_W = SRAM_DATA_WIDTH,
  parameter int RD_LAT = SRAM_RD_LAT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_wdata,
  output logic [NUM_CH-1:0]        o_gnt,
  output logic [NUM_CH-1:0]        o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [ADDR_W-1:0]        o_sram_addr,
  inout  wire  [DATA_W-1:0]        io_sram_dq,
  output logic                     o_sram_we_n
);

  sram_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) arb ();

  ch_id_t            ptr;
  logic              accept;
  ch_id_t            win_ch;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              we_n_q;
  logic [DATA_W-1:0] wdata_q;
  rd_slot_t          pipe [RD_LAT];

  // Masking requests in reset keeps the grant low without touching the picker.
  assign arb.req   = i_rst ? '0 : i_req;
  assign arb.we    = i_we;
  assign arb.addr  = i_addr;
  assign arb.wdata = i_wdata;
  assign o_gnt     = arb.gnt;
  assign accept    = |arb.gnt;

  sram_arb_picker #(.NUM_CH(NUM_CH)) u_picker (
    .bus (arb.slave),
    .ptr (ptr)
  );

  always_comb begin
    win_ch    = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb.gnt[k]) begin
        win_ch    = ch_id_t'(k);
        win_we    = arb.we[k];
        win_addr  = arb.addr[k*ADDR_W +: ADDR_W];
        win_wdata = arb.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(win_ch) == NUM_CH - 1) ? '0 : win_ch + ch_id_t'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Issue stage: the granted access drives the pins in the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sram_addr <= '0;
      we_n_q      <= 1'b1;
    end else begin
      we_n_q <= !(accept && win_we);
      if (accept) begin
        o_sram_addr <= win_addr;
      end
    end
  end

  // NOTE: write data is a pure datapath register and is left unreset; it only
  // reaches the pins while we_n_q is low, which reset already prevents.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      wdata_q <= win_wdata;
    end
  end

  assign o_sram_we_n = we_n_q;
  assign io_sram_dq  = we_n_q ? {DATA_W{1'bz}} : wdata_q;

  // Read-return tracker: one slot per cycle of SRAM latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: accept && !win_we, ch: win_ch};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= '0;
      o_rdata  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        o_rvalid[k] <= pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].ch == ch_id_t'(k));
      end
      if (pipe[RD_LAT-1].valid) begin
        o_rdata <= io_sram_dq;
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset: the reset is synchronous and active-high, the clock is i_clk, and the reset is i_rst.
REQ-002 Parameter NUM_CH, default 2: number of requester channels, range 2..8.
REQ-003 Parameter ADDR_W, default sram_pkg::SRAM_ADDR_COUNT: SRAM address width.
REQ-004 Parameter DATA_W, default sram_pkg::SRAM_DATA_WIDTH: SRAM data width.
REQ-005 Parameter RD_LAT, default 2: cycles from pin address to captured read data, range 1..4.
REQ-006 Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  NUM_CH  per-channel access request; held until granted.
- i_we  in  NUM_CH  per-channel write (1) or read (0).
- i_addr  in  NUM_CH*ADDR_W  flattened per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- i_wdata  in  NUM_CH*DATA_W  flattened per-channel write data.
- o_gnt  out  NUM_CH  one-hot grant, combinational, at most one bit set.
- o_rvalid  out  NUM_CH  one-hot read-data-valid pulse.
- o_rdata  out  DATA_W  read data, shared by all channels; meaningful only while o_rvalid is nonzero.
- o_sram_addr  out  ADDR_W  SRAM address pins.
- io_sram_dq  inout  DATA_W  SRAM data pins; driven only in write cycles, otherwise high-Z.
- o_sram_we_n  out  1  SRAM write enable, active-low.

Function
REQ-007 The arbiter SHALL issue at most one access per cycle: a cycle with i_req[k]=1 and o_gnt[k]=1 is an accepted access for channel k.
REQ-008 With no request pending, o_gnt SHALL be all zeros.
REQ-009 The accepted access SHALL be registered, and its address, we_n and write data SHALL appear on the SRAM pins in cycle N+1 (issue stage).
REQ-010 In an issue cycle that is not a write, and in any idle cycle, io_sram_dq SHALL be high-Z and o_sram_we_n SHALL be 1.
REQ-011 In an idle cycle, o_sram_addr SHALL hold its previous value.
REQ-012 For a read accepted in cycle N, the module SHALL sample io_sram_dq in cycle N+1+RD_LAT into o_rdata and assert o_rvalid[k] for exactly that one cycle.
REQ-013 Read returns SHALL be tracked in an RD_LAT-deep shift pipeline of (valid, channel id).
REQ-014 Back-to-back reads SHALL be accepted every cycle with full throughput.
REQ-015 Writes SHALL produce no o_rvalid pulse.
REQ-016 A write immediately following a read, or a read immediately following a write, SHALL need no bubble cycle.
REQ-017 A request deasserted before it is granted SHALL cause no SRAM access.
REQ-018 i_addr, i_we and i_wdata SHALL be sampled only in the grant cycle.
REQ-019 Fixed-priority mode: the lowest-index requesting channel SHALL win, so channel 0 (the real-time display path) is never blocked by another channel.
REQ-020 Round-robin mode: the rotation pointer SHALL advance to the channel after the winner, only on an accepted access.
REQ-021 Round-robin mode: any continuously requesting channel SHALL be granted within NUM_CH cycles.
REQ-022 Round-robin mode: when only one channel is requesting, it SHALL be granted every cycle regardless of the pointer.

Reset
REQ-023 While i_rst=1 the module SHALL force o_gnt=0, o_rvalid=0, o_rdata=0, o_sram_addr=0, o_sram_we_n=1 and io_sram_dq=high-Z.
REQ-024 While i_rst=1 the module SHALL set the round-robin pointer to 0.
REQ-025 Reset asserted mid-operation SHALL flush the read pipeline: no o_rvalid pulse is emitted afterwards for any access accepted before reset.
REQ-026 Reset asserted mid-operation SHALL abort a write in its issue stage, with o_sram_we_n high in the next cycle.

Configuration
REQ-027 Macro SRAM_ARB_RR_EN: when defined, the module SHALL use round-robin arbitration (REQ-020 to REQ-022).
REQ-028 When SRAM_ARB_RR_EN is not defined, the module SHALL use fixed priority (REQ-019), and no pointer register SHALL exist.

Structure
REQ-029 SRAM_ADDR_COUNT, SRAM_DATA_WIDTH and SRAM_RD_LAT SHALL reside in sram_pkg, and RD_LAT SHALL default from SRAM_RD_LAT.
REQ-030 A sub-module sram_arb_picker SHALL compute the one-hot grant combinationally from the request vector and the pointer; the tristate and the pipeline live in sram_port_arbiter.

Verification
REQ-031 Fixed priority, NUM_CH=2: ch0 and ch1 both request reads from 0x00010 and 0x00020 -> ch0 granted first, ch1 one cycle later; o_rvalid[0] at N+3, o_rvalid[1] at N+4 (RD_LAT=2).
REQ-032 Round-robin, NUM_CH=4: all channels request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-033 ch1 writes 0xBEEF to 0x00100, then ch0 reads 0x00100 the next cycle -> pins show we_n=0 then we_n=1 with no bubble; o_rdata=0xBEEF with o_rvalid[0].
REQ-034 A read accepted in cycle N, with i_rst pulsed in cycle N+1 -> no o_rvalid pulse ever appears; all outputs at their reset values.
REQ-035 ch2 raises i_req for one cycle while a higher-priority channel holds the bus in fixed mode, then drops it -> no access to ch2's address appears on the pins.
REQ-036 Idle bus -> io_sram_dq is high-Z and o_sram_we_n=1 in every cycle; o_sram_addr stays unchanged.
